// File: rtl/shuffle_writeback_pkg.sv
// Shared widths, word layout and line-index extraction for the shuffle write-back stage.
package shuffle_writeback_pkg;

    localparam int unsigned HALF_W     = 64;
    localparam int unsigned WORD_W     = 2 * HALF_W;
    localparam int unsigned HI_LSB     = HALF_W;
    localparam int unsigned LO_LSB     = 0;
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned SLOTS      = 4;
    localparam int unsigned SLOT_W     = 2;
    localparam int unsigned ITERATIONS = 262144;
    localparam int unsigned ITER_W     = 18;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LINE_LSB   = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t               p;
        word_t               a;
        logic [ADDR_W-1:0]   addr;
        logic [ADDR_W-1:0]   next_addr;
        logic [SLOT_W-1:0]   slot;
    } wb_entry_t;

    // 16-byte scratchpad line index addressed by a 128-bit word
    function automatic logic [ADDR_W-1:0] line_index(input word_t w);
        return w[ADDR_W+LINE_LSB-1:LINE_LSB];
    endfunction

endpackage

// File: rtl/shuffle_writeback_fifo.sv
// Generic synchronous FIFO; count-based full/empty, pointers wrap modulo DEPTH (power of two).
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/shuffle_writeback.sv
// Buffers multiply-add results, writes them back to the scratchpad and hands a' = p ^ rd
// to slot re-issue with an atomic joint handshake; tracks per-slot iteration counts.
module shuffle_writeback
    import shuffle_writeback_pkg::*;
#(
    parameter int unsigned ITERATIONS = shuffle_writeback_pkg::ITERATIONS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_p,
    input  logic [WORD_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic [SLOTS-1:0]  slot_clear,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_a,
    output logic [ADDR_W-1:0] out_addr,
    output logic [SLOT_W-1:0] out_slot,
    output logic              out_last,
    output logic              err_overflow
);
    localparam int unsigned CNT_W = $clog2(ITERATIONS);

    word_t            a_c;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [CNT_W-1:0] iter [SLOTS];

    assign a_c        = in_p ^ in_rd;
    assign push_entry = '{p: in_p, a: a_c, addr: in_addr, next_addr: line_index(a_c), slot: in_slot};

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // write-back and next-state transfer only ever happen together
    assign pop       = !fifo_empty && wr_ready && out_ready;
    assign in_ready  = !fifo_full;
    assign wr_valid  = !fifo_empty;
    assign out_valid = !fifo_empty;
    assign wr_addr   = head.addr;
    assign wr_data   = head.p;
    assign out_a     = head.a;
    assign out_addr  = head.next_addr;
    assign out_slot  = head.slot;
    assign out_last  = !fifo_empty && (iter[head.slot] == CNT_W'(ITERATIONS - 1));

    // a clear wins over a same-cycle pop increment of that slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SLOTS; s++) iter[s] <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (slot_clear[s]) begin
                    iter[s] <= '0;
                end else if (pop && (head.slot == SLOT_W'(s))) begin
                    iter[s] <= out_last ? '0 : iter[s] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow <= 1'b0;
        end else if (in_valid && fifo_full) begin
            err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shuffle_writeback.sv
// Scoreboard bench for shuffle_writeback; runs with a short iteration count so wraps are reachable.
module tb_shuffle_writeback;
    import shuffle_writeback_pkg::*;

    localparam int unsigned TB_ITER = 64;

    typedef struct {
        word_t             p;
        word_t             a;
        logic [ADDR_W-1:0] addr;
        logic [SLOT_W-1:0] slot;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_p;
    logic [WORD_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_addr;
    logic [SLOT_W-1:0] in_slot;
    logic [SLOTS-1:0]  slot_clear;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_a;
    logic [ADDR_W-1:0] out_addr;
    logic [SLOT_W-1:0] out_slot;
    logic              out_last;
    logic              err_overflow;

    exp_t        q[$];
    int unsigned m_iter[SLOTS];
    bit          m_err;
    int          compared = 0;
    int          mismatched = 0;

    shuffle_writeback #(.ITERATIONS(TB_ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_p         (in_p),
        .in_rd        (in_rd),
        .in_addr      (in_addr),
        .in_slot      (in_slot),
        .slot_clear   (slot_clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_addr     (out_addr),
        .out_slot     (out_slot),
        .out_last     (out_last),
        .err_overflow (err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] exp_line(input word_t a);
        word_t t;
        t = a;
        return t[21:4];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int s = 0; s < SLOTS; s++) m_iter[s] = 0;
        m_err = 1'b0;
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_p       = '0;
        in_rd      = '0;
        in_addr    = '0;
        in_slot    = '0;
        slot_clear = '0;
    endtask

    task automatic drive_beat(input word_t p, input word_t rd, input logic [ADDR_W-1:0] addr,
                              input logic [SLOT_W-1:0] slot);
        in_valid = 1'b1;
        in_p     = p;
        in_rd    = rd;
        in_addr  = addr;
        in_slot  = slot;
    endtask

    // reference model update for the upcoming edge, then step to the next negedge
    task automatic advance();
        bit   mpush;
        bit   mpop;
        exp_t e;
        mpush = in_valid && (q.size() < FIFO_DEPTH);
        mpop  = (q.size() != 0) && wr_ready && out_ready;
        if (in_valid && !mpush) m_err = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot_clear[s]) m_iter[s] = 0;
            else if (mpop && (int'(q[0].slot) == s)) m_iter[s] = (m_iter[s] == TB_ITER - 1) ? 0 : m_iter[s] + 1;
        end
        if (mpop) void'(q.pop_front());
        if (mpush) begin
            e.p = in_p; e.a = in_p ^ in_rd; e.addr = in_addr; e.slot = in_slot;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        wr_ready  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(rand_word(), rand_word(), ADDR_W'($urandom), SLOT_W'($urandom_range(0, 3)));
            advance();
        end
        drive_idle();
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL reset_prefill_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        model_reset();
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        compared++; if (wr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++; if (out_last !== 1'b0) begin mismatched++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err_overflow); end
        @(negedge clk);
        rst      = 1'b0;
        wr_ready = 1'b1;
        advance();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_post_valid: got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_post_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        word_t p;
        p = 128'h0123456789ABCDEF_FEDCBA9876543210;
        wr_ready  = 1'b1;
        out_ready = 1'b1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_pre_valid: got %b want 0", out_valid); end
        drive_beat(p, '1, 18'h00ABC, 2'd0);
        advance();
        drive_idle();
        compared++; if (wr_valid !== 1'b1 || out_valid !== 1'b1) begin mismatched++; $display("FAIL single_latency: got wr=%b out=%b want 1 1", wr_valid, out_valid); end
        compared++; if (wr_data !== p) begin mismatched++; $display("FAIL single_wr_data: got %h want %h", wr_data, p); end
        compared++; if (wr_addr !== 18'h00ABC) begin mismatched++; $display("FAIL single_wr_addr: got %h want 00abc", wr_addr); end
        compared++; if (out_a !== 128'hFEDCBA9876543210_0123456789ABCDEF) begin mismatched++; $display("FAIL single_out_a: got %h want %h", out_a, ~p); end
        compared++; if (out_addr !== 18'h2BCDE) begin mismatched++; $display("FAIL single_out_addr: got %h want 2bcde", out_addr); end
        compared++; if (out_slot !== 2'd0 || out_last !== 1'b0) begin mismatched++; $display("FAIL single_slot_last: got %0d %b want 0 0", out_slot, out_last); end
        advance();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        wr_ready  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            compared++; if (in_ready !== (i < 4)) begin mismatched++; $display("FAIL bp_in_ready cyc=%0d: got %b want %b", i, in_ready, i < 4); end
            compared++; if (out_valid !== (i > 0)) begin mismatched++; $display("FAIL bp_out_valid cyc=%0d: got %b want %b", i, out_valid, i > 0); end
            if (i < 5) drive_beat(rand_word(), rand_word(), ADDR_W'($urandom), SLOT_W'($urandom_range(0, 3)));
            else drive_idle();
            advance();
        end
        compared++; if (err_overflow !== 1'b1) begin mismatched++; $display("FAIL bp_err_set: got %b want 1", err_overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (out_valid !== 1'b1 || q.size() == 0) begin mismatched++; $display("FAIL bp_release_valid pop=%0d: got %b want 1", i, out_valid); end
            else begin
                compared++; if (wr_data !== q[0].p || out_a !== q[0].a) begin mismatched++; $display("FAIL bp_order pop=%0d: got p=%h a=%h want p=%h a=%h", i, wr_data, out_a, q[0].p, q[0].a); end
                compared++; if (wr_addr !== q[0].addr || out_slot !== q[0].slot) begin mismatched++; $display("FAIL bp_addr_slot pop=%0d: got %h %0d want %h %0d", i, wr_addr, out_slot, q[0].addr, q[0].slot); end
            end
            advance();
        end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        compared++; if (err_overflow !== 1'b1) begin mismatched++; $display("FAIL bp_err_sticky: got %b want 1", err_overflow); end
    endtask

    task automatic test_counter_wrap();
        int slot2_pops;
        int h;
        logic [SLOT_W-1:0] s;
        slot2_pops = 0;
        wr_ready   = 1'b1;
        out_ready  = 1'b1;
        // 64 beats of slot 2, one of slot 0, one more of slot 2
        for (int k = 0; k <= 66; k++) begin
            h = k - 1;
            if (h >= 0) begin
                compared++; if (out_valid !== 1'b1 || q.size() == 0) begin mismatched++; $display("FAIL wrap_valid beat=%0d: got %b want 1", h, out_valid); end
                else begin
                    compared++; if (out_slot !== q[0].slot || wr_data !== q[0].p) begin mismatched++; $display("FAIL wrap_head beat=%0d: got slot %0d want %0d", h, out_slot, q[0].slot); end
                    if (q[0].slot == 2'd2) begin
                        compared++; if (out_last !== (slot2_pops == TB_ITER - 1)) begin mismatched++; $display("FAIL wrap_last slot2 pop=%0d: got %b want %b", slot2_pops, out_last, slot2_pops == TB_ITER - 1); end
                        slot2_pops++;
                    end else begin
                        compared++; if (out_last !== 1'b0) begin mismatched++; $display("FAIL wrap_other_slot_last: got %b want 0", out_last); end
                    end
                end
            end
            if (k < 66) begin
                s = (k == 64) ? 2'd0 : 2'd2;
                drive_beat(rand_word(), rand_word(), ADDR_W'($urandom), s);
            end else drive_idle();
            advance();
        end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL wrap_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_slot_clear();
        int h;
        wr_ready  = 1'b1;
        out_ready = 1'b1;
        // beats 0..3 count slot 1 to 3, the pop of beat 3 coincides with clear
        for (int k = 0; k <= 68; k++) begin
            h = k - 1;
            slot_clear = (h == 3) ? 4'b0010 : 4'b0000;
            if (h >= 0) begin
                compared++; if (out_valid !== 1'b1 || q.size() == 0) begin mismatched++; $display("FAIL clr_valid beat=%0d: got %b want 1", h, out_valid); end
                else begin
                    compared++; if (out_a !== q[0].a || out_addr !== exp_line(q[0].a)) begin mismatched++; $display("FAIL clr_head beat=%0d: got %h %h want %h %h", h, out_a, out_addr, q[0].a, exp_line(q[0].a)); end
                    compared++; if (out_last !== (h == 67)) begin mismatched++; $display("FAIL clr_last beat=%0d: got %b want %b", h, out_last, h == 67); end
                end
            end
            if (k < 68) drive_beat(rand_word(), rand_word(), ADDR_W'($urandom), 2'd1);
            else begin
                in_valid = 1'b0;
            end
            advance();
        end
        slot_clear = '0;
    endtask

    task automatic test_streaming();
        bit exp_last;
        wr_ready  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= 1000; k++) begin
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready cyc=%0d: got %b want 1", k, in_ready); end
            compared++; if (out_valid !== (k > 0)) begin mismatched++; $display("FAIL stream_occupancy cyc=%0d: got %b want %b", k, out_valid, k > 0); end
            if (q.size() != 0) begin
                exp_last = (m_iter[q[0].slot] == TB_ITER - 1);
                compared++; if (wr_data !== q[0].p || out_a !== q[0].a || wr_addr !== q[0].addr || out_slot !== q[0].slot) begin mismatched++; $display("FAIL stream_seq cyc=%0d: got p=%h slot=%0d want p=%h slot=%0d", k, wr_data, out_slot, q[0].p, q[0].slot); end
                compared++; if (out_addr !== exp_line(q[0].a) || out_last !== exp_last) begin mismatched++; $display("FAIL stream_addr_last cyc=%0d: got %h %b want %h %b", k, out_addr, out_last, exp_line(q[0].a), exp_last); end
            end
            if (k < 1000) drive_beat(rand_word(), rand_word(), ADDR_W'($urandom), SLOT_W'($urandom_range(0, 3)));
            else drive_idle();
            advance();
        end
        compared++; if (err_overflow !== 1'b0) begin mismatched++; $display("FAIL stream_err: got %b want 0", err_overflow); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drained: got %b want 0", out_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        wr_ready  = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        apply_reset();
        test_counter_wrap();
        test_slot_clear();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
